// File: rtl/user_pkg.sv
// Shared types and constants for the user-domain audio filter scheduling slice.
package user_pkg;

   localparam int unsigned AuNumChan      = 2;
   localparam int unsigned AuSampleWidth  = 32;
   localparam int unsigned AuChanIdxWidth = (AuNumChan > 1) ? $clog2(AuNumChan) : 1;

   typedef logic [AuSampleWidth-1:0]  au_sample_t;
   typedef logic [AuChanIdxWidth-1:0] au_chan_idx_t;

   // Issue FSM: wait for a winner, then hold the captured sample until the filter takes it
   typedef enum logic {
      ArbIdle  = 1'b0,
      ArbIssue = 1'b1
   } au_arb_state_e;

endpackage

// File: rtl/user_au_tag_fifo.sv
// In-order FIFO of channel indices recording which channel owns each sample inside the filter.
module user_au_tag_fifo
   import user_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = AuChanIdxWidth,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  usage_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             do_push_c;
   logic             do_pop_c;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o    = (cnt_q == CntW'(Depth));
   assign empty_o   = (cnt_q == '0);
   assign usage_o   = cnt_q;
   assign head_o    = mem_q[rd_ptr_q];

   // A pop frees the slot a same-cycle push needs when full; a pop on empty is ignored
   assign do_pop_c  = pop_i & ~empty_o;
   assign do_push_c = push_i & (~full_o | pop_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push_c, do_pop_c})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push_c) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/user_au_chan_arb.sv
// Round-robin scheduler sharing one in-order audio filter between several sample streams,
// tagging each issued sample and steering each filtered result back to its channel.
module user_au_chan_arb
   import user_pkg::*;
#(
   parameter int unsigned NumChan     = AuNumChan,
   parameter int unsigned DataWidth   = AuSampleWidth,
   parameter int unsigned MaxInFlight = 4,
   localparam int unsigned CntW       = $clog2(MaxInFlight + 1)
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NumChan-1:0]                chan_en_i,
   input  logic [NumChan-1:0][DataWidth-1:0] ch_data_i,
   input  logic [NumChan-1:0]                ch_valid_i,
   output logic [NumChan-1:0]                ch_ready_o,
   output logic [DataWidth-1:0]              flt_data_o,
   output logic                              flt_valid_o,
   input  logic                              flt_ready_i,
   input  logic [DataWidth-1:0]              flt_data_i,
   input  logic                              flt_valid_i,
   output logic                              flt_ready_o,
   output logic [NumChan-1:0][DataWidth-1:0] out_data_o,
   output logic [NumChan-1:0]                out_valid_o,
   input  logic [NumChan-1:0]                out_ready_i,
   output logic [CntW-1:0]                   inflight_o,
   output logic                              err_o
);

   localparam int unsigned IdxW = (NumChan > 1) ? $clog2(NumChan) : 1;

   typedef logic [IdxW-1:0] idx_t;

   au_arb_state_e        state_q, state_d;
   idx_t                 rr_ptr_q, rr_ptr_d;
   idx_t                 gnt_idx_q, gnt_idx_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 err_q;

   logic [NumChan-1:0]   cand_c;
   logic                 pick_found_c;
   idx_t                 pick_idx_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 spur_c;

   idx_t                 fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CntW-1:0]      fifo_usage;

   // First requesting channel at or after ptr, wrapping; MSB of the result flags a hit
   function automatic logic [IdxW:0] rr_pick(input logic [NumChan-1:0] cand, input idx_t ptr);
      logic        found;
      idx_t        idx;
      logic [31:0] pos;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < NumChan; k++) begin
         pos = (32'(ptr) + 32'(k)) % 32'(NumChan);
         if (!found && cand[pos]) begin
            found = 1'b1;
            idx   = IdxW'(pos);
         end
      end
      return {found, idx};
   endfunction

   assign cand_c                     = ch_valid_i & chan_en_i;
   assign {pick_found_c, pick_idx_c} = rr_pick(cand_c, rr_ptr_q);

   // Samples held in the output register count as in flight alongside queued tags
   assign inflight_o  = fifo_usage + CntW'(state_q == ArbIssue);
   assign flt_valid_o = (state_q == ArbIssue);
   assign flt_data_o  = data_q;
   assign err_o       = err_q;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_idx_d  = gnt_idx_q;
      data_d     = data_q;
      ch_ready_o = '0;
      push_c     = 1'b0;
      case (state_q)
         ArbIdle: begin
            if (pick_found_c && (inflight_o < CntW'(MaxInFlight)) && !fifo_full) begin
               ch_ready_o[pick_idx_c] = 1'b1;
               data_d                 = ch_data_i[pick_idx_c];
               gnt_idx_d              = pick_idx_c;
               state_d                = ArbIssue;
            end
         end
         ArbIssue: begin
            if (flt_ready_i) begin
               push_c   = 1'b1;
               rr_ptr_d = (gnt_idx_q == IdxW'(NumChan - 1)) ? '0 : gnt_idx_q + IdxW'(1);
               state_d  = ArbIdle;
            end
         end
         default: state_d = ArbIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ArbIdle;
         rr_ptr_q  <= '0;
         gnt_idx_q <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_idx_q <= gnt_idx_d;
         data_q    <= data_d;
         err_q     <= err_q | spur_c;
      end
   end

   // Return path: the head tag picks the lane; an empty queue swallows stray results
   assign spur_c      = flt_valid_i & fifo_empty;
   assign flt_ready_o = fifo_empty ? 1'b1 : out_ready_i[fifo_head];
   assign pop_c       = flt_valid_i & ~fifo_empty & out_ready_i[fifo_head];
   assign out_data_o  = {NumChan{flt_data_i}};

   always_comb begin
      out_valid_o            = '0;
      out_valid_o[fifo_head] = flt_valid_i & ~fifo_empty;
   end

   user_au_tag_fifo #(
      .Depth (MaxInFlight),
      .Width (IdxW)
   ) u_tag_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push_c),
      .push_data_i (gnt_idx_q),
      .pop_i       (pop_c),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .usage_o     (fifo_usage)
   );

endmodule

// File: tb/tb_user_au_chan_arb.sv
// Bench for user_au_chan_arb: queue-based reference model checked every cycle plus directed scenarios.
module tb_user_au_chan_arb;

   localparam int NCH  = 2;
   localparam int MAXF = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic [1:0]           chan_en_i = 2'b11;
   logic [1:0][31:0]     ch_data_i = '0;
   logic [1:0]           ch_valid_i = '0;
   logic [1:0]           ch_ready_o;
   logic [31:0]          flt_data_o;
   logic                 flt_valid_o;
   logic                 flt_ready_i = 1'b1;
   logic [31:0]          flt_data_i = '0;
   logic                 flt_valid_i = 1'b0;
   logic                 flt_ready_o;
   logic [1:0][31:0]     out_data_o;
   logic [1:0]           out_valid_o;
   logic [1:0]           out_ready_i = 2'b11;
   logic [2:0]           inflight_o;
   logic                 err_o;

   user_au_chan_arb #(
      .NumChan     (NCH),
      .DataWidth   (32),
      .MaxInFlight (MAXF)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .chan_en_i   (chan_en_i),
      .ch_data_i   (ch_data_i),
      .ch_valid_i  (ch_valid_i),
      .ch_ready_o  (ch_ready_o),
      .flt_data_o  (flt_data_o),
      .flt_valid_o (flt_valid_o),
      .flt_ready_i (flt_ready_i),
      .flt_data_i  (flt_data_i),
      .flt_valid_i (flt_valid_i),
      .flt_ready_o (flt_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .inflight_o  (inflight_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { int ch; logic [31:0] d; } ent_t;
   typedef struct { logic [31:0] d; int t; } flt_ent_t;

   // reference model: pending sample + ordered list of samples inside the filter
   ent_t        m_tags[$];
   bit          m_pend;
   int          m_pend_ch;
   logic [31:0] m_pend_d;
   int          m_rr;
   bit          m_err;

   // environment: channel sources, echo filter, logs
   logic [31:0] src0[$];
   logic [31:0] src1[$];
   flt_ent_t    flt_q[$];
   ent_t        rcv_log[$];
   int          gnt_log[$];
   bit          ret_en;
   int          ret_budget;
   bit          spur_req;
   bit          spur_active;

   int cyc;
   int checks;
   int errors;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic ent_t rcv_at(input int i);
      ent_t e;
      e.ch = -1;
      e.d  = '0;
      if (i < rcv_log.size()) e = rcv_log[i];
      return e;
   endfunction

   function automatic int gnt_at(input int i);
      return (i < gnt_log.size()) ? gnt_log[i] : -1;
   endfunction

   task automatic monitor();
      logic [1:0] cand;
      logic [1:0] exp_rdy;
      logic [1:0] exp_ov;
      logic       exp_frdy;
      int         win;
      ent_t       e;
      flt_ent_t   f;
      cyc++;
      if (rst_i) begin
         m_tags.delete();
         flt_q.delete();
         m_pend = 0;
         m_rr   = 0;
         m_err  = 0;
         return;
      end
      cand = ch_valid_i & chan_en_i;
      win  = -1;
      if (!m_pend && m_tags.size() < MAXF)
         for (int k = 0; k < NCH; k++)
            if (win < 0 && cand[(m_rr + k) % NCH]) win = (m_rr + k) % NCH;
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      exp_ov   = '0;
      exp_frdy = 1'b1;
      if (m_tags.size() > 0) begin
         exp_frdy = out_ready_i[m_tags[0].ch];
         if (flt_valid_i) exp_ov[m_tags[0].ch] = 1'b1;
      end
      chk("ch_ready", 64'(ch_ready_o), 64'(exp_rdy));
      chk("flt_valid", 64'(flt_valid_o), 64'(m_pend));
      if (m_pend) chk("flt_data", 64'(flt_data_o), 64'(m_pend_d));
      chk("out_valid", 64'(out_valid_o), 64'(exp_ov));
      chk("flt_ready", 64'(flt_ready_o), 64'(exp_frdy));
      chk("inflight", 64'(inflight_o), 64'(m_tags.size() + int'(m_pend)));
      chk("err", 64'(err_o), 64'(m_err));
      if (|out_valid_o)
         for (int c = 0; c < NCH; c++) chk("out_data", 64'(out_data_o[c]), 64'(flt_data_i));

      if (flt_valid_i && exp_frdy) begin
         if (m_tags.size() > 0) begin
            e = m_tags.pop_front();
            chk("ret_data", 64'(flt_data_i), 64'(e.d));
         end else begin
            m_err = 1;
         end
      end
      if (m_pend && flt_ready_i) begin
         e.ch = m_pend_ch;
         e.d  = m_pend_d;
         m_tags.push_back(e);
         m_rr   = (m_pend_ch + 1) % NCH;
         m_pend = 0;
      end else if (win >= 0) begin
         m_pend    = 1;
         m_pend_ch = win;
         m_pend_d  = ch_data_i[win];
      end

      for (int c = 0; c < NCH; c++)
         if (out_valid_o[c] && out_ready_i[c]) begin
            e.ch = c;
            e.d  = out_data_o[c];
            rcv_log.push_back(e);
         end
      if (ch_ready_o[0] && ch_valid_i[0]) begin gnt_log.push_back(0); void'(src0.pop_front()); end
      if (ch_ready_o[1] && ch_valid_i[1]) begin gnt_log.push_back(1); void'(src1.pop_front()); end
      if (flt_valid_o && flt_ready_i) begin
         f.d = flt_data_o;
         f.t = cyc + 2;
         flt_q.push_back(f);
      end
      if (flt_valid_i && flt_ready_o && !spur_active && flt_q.size() > 0) begin
         void'(flt_q.pop_front());
         if (ret_budget > 0) ret_budget--;
      end
   endtask

   task automatic drive();
      ch_valid_i[0] = (src0.size() > 0);
      ch_data_i[0]  = (src0.size() > 0) ? src0[0] : '0;
      ch_valid_i[1] = (src1.size() > 0);
      ch_data_i[1]  = (src1.size() > 0) ? src1[0] : '0;
      if (spur_req) begin
         flt_valid_i = 1'b1;
         flt_data_i  = 32'h0BAD_0BAD;
         spur_req    = 0;
         spur_active = 1;
      end else begin
         spur_active = 0;
         if (ret_en && ret_budget != 0 && flt_q.size() > 0 && cyc >= flt_q[0].t) begin
            flt_valid_i = 1'b1;
            flt_data_i  = flt_q[0].d;
         end else begin
            flt_valid_i = 1'b0;
            flt_data_i  = '0;
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk_i);
         monitor();
         @(posedge clk_i);
         #1;
         drive();
      end
   endtask

   task automatic do_reset();
      src0.delete();
      src1.delete();
      ret_en     = 1;
      ret_budget = -1;
      spur_req   = 0;
      rst_i      = 1'b1;
      tick(2);
      rst_i = 1'b0;
      gnt_log.delete();
      rcv_log.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;

      // reset state
      do_reset();
      chk("rst_flt_valid", 64'(flt_valid_o), 64'(0));
      chk("rst_ch_ready", 64'(ch_ready_o), 64'(0));
      chk("rst_out_valid", 64'(out_valid_o), 64'(0));
      chk("rst_flt_ready", 64'(flt_ready_o), 64'(1));
      chk("rst_inflight", 64'(inflight_o), 64'(0));
      chk("rst_err", 64'(err_o), 64'(0));

      // single channel through an echo filter
      src0.push_back(32'h11);
      src0.push_back(32'h22);
      tick(20);
      chk("t1_rcv_cnt", 64'(rcv_log.size()), 64'(2));
      chk("t1_rcv0_ch", 64'(rcv_at(0).ch), 64'(0));
      chk("t1_rcv0_d", 64'(rcv_at(0).d), 64'h11);
      chk("t1_rcv1_ch", 64'(rcv_at(1).ch), 64'(0));
      chk("t1_rcv1_d", 64'(rcv_at(1).d), 64'h22);
      chk("t1_inflight", 64'(inflight_o), 64'(0));

      // both channels busy from reset: alternating grants and routing
      do_reset();
      for (int i = 0; i < 4; i++) begin
         src0.push_back(32'hA0 + 32'(i));
         src1.push_back(32'hB0 + 32'(i));
      end
      tick(40);
      for (int i = 0; i < 4; i++) chk("t2_gnt_order", 64'(gnt_at(i)), 64'(i % 2));
      chk("t2_rcv_cnt", 64'(rcv_log.size()), 64'(8));
      chk("t2_rcv0_ch", 64'(rcv_at(0).ch), 64'(0));
      chk("t2_rcv0_d", 64'(rcv_at(0).d), 64'hA0);
      chk("t2_rcv1_ch", 64'(rcv_at(1).ch), 64'(1));
      chk("t2_rcv1_d", 64'(rcv_at(1).d), 64'hB0);
      chk("t2_rcv7_d", 64'(rcv_at(7).d), 64'hB3);

      // filter stalls for 10 cycles
      do_reset();
      src0.push_back(32'h31);
      src0.push_back(32'h32);
      flt_ready_i = 1'b0;
      tick(10);
      chk("t3_gnt_stall", 64'(gnt_log.size()), 64'(1));
      chk("t3_hold_valid", 64'(flt_valid_o), 64'(1));
      chk("t3_hold_data", 64'(flt_data_o), 64'h31);
      flt_ready_i = 1'b1;
      tick(15);
      chk("t3_gnt_resume", 64'(gnt_log.size()), 64'(2));
      chk("t3_rcv_cnt", 64'(rcv_log.size()), 64'(2));

      // filter never returns: credit limit, then one return frees one grant
      do_reset();
      ret_en = 0;
      for (int i = 0; i < 6; i++) begin
         src0.push_back(32'hD0 + 32'(i));
         src1.push_back(32'hE0 + 32'(i));
      end
      tick(20);
      chk("t4_gnt_limit", 64'(gnt_log.size()), 64'(4));
      chk("t4_inflight_full", 64'(inflight_o), 64'(4));
      chk("t4_no_ready", 64'(ch_ready_o), 64'(0));
      ret_en     = 1;
      ret_budget = 1;
      tick(12);
      chk("t4_gnt_plus1", 64'(gnt_log.size()), 64'(5));
      chk("t4_inflight_again", 64'(inflight_o), 64'(4));
      chk("t4_rcv_one", 64'(rcv_log.size()), 64'(1));
      ret_budget = -1;
      tick(60);
      chk("t4_gnt_all", 64'(gnt_log.size()), 64'(12));
      chk("t4_drained", 64'(inflight_o), 64'(0));

      // blocked ch1 head back-pressures the filter without reordering
      do_reset();
      out_ready_i = 2'b01;
      src1.push_back(32'hC1);
      tick(3);
      src0.push_back(32'hC0);
      tick(12);
      chk("t5_bp_ready", 64'(flt_ready_o), 64'(0));
      chk("t5_bp_valid", 64'(out_valid_o), 64'(2'b10));
      chk("t5_no_rcv", 64'(rcv_log.size()), 64'(0));
      chk("t5_inflight", 64'(inflight_o), 64'(2));
      out_ready_i = 2'b11;
      tick(10);
      chk("t5_rcv_cnt", 64'(rcv_log.size()), 64'(2));
      chk("t5_rcv0_ch", 64'(rcv_at(0).ch), 64'(1));
      chk("t5_rcv0_d", 64'(rcv_at(0).d), 64'hC1);
      chk("t5_rcv1_ch", 64'(rcv_at(1).ch), 64'(0));
      chk("t5_rcv1_d", 64'(rcv_at(1).d), 64'hC0);

      // disabled channel is skipped until re-enabled
      do_reset();
      chan_en_i = 2'b10;
      src0.push_back(32'h51);
      src1.push_back(32'h61);
      src1.push_back(32'h62);
      tick(20);
      chk("t6_gnt_masked", 64'(gnt_log.size()), 64'(2));
      chk("t6_ch0_waiting", 64'(src0.size()), 64'(1));
      chan_en_i = 2'b11;
      tick(12);
      chk("t6_gnt_enabled", 64'(gnt_log.size()), 64'(3));

      // stray filter result with nothing in flight
      do_reset();
      spur_req = 1;
      tick(1);
      chk("t7_spur_ready", 64'(flt_ready_o), 64'(1));
      chk("t7_spur_noout", 64'(out_valid_o), 64'(0));
      tick(1);
      chk("t7_err_set", 64'(err_o), 64'(1));
      tick(5);
      chk("t7_err_sticky", 64'(err_o), 64'(1));
      do_reset();
      chk("t7_err_cleared", 64'(err_o), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
